// File: rtl/alu_risc_mc_controller.sv
// +--------------------------------------------------------------------------+
// | alu_risc_mc_controller                                                   |
// | Multicycle RISC-V control FSM and ALU decoder driving the alu_risc path. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_risc_mc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       IllegalOp
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [6:0] C_OP_LW  = 7'b0000011;
  localparam logic [6:0] C_OP_SW  = 7'b0100011;
  localparam logic [6:0] C_OP_R   = 7'b0110011;
  localparam logic [6:0] C_OP_I   = 7'b0010011;
  localparam logic [6:0] C_OP_JAL = 7'b1101111;
  localparam logic [6:0] C_OP_BEQ = 7'b1100011;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] w_state;
  logic       w_pc_update;
  logic       w_branch;
  logic [1:0] w_alu_op;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          C_OP_LW, C_OP_SW: state_d = S_MEMADR;
          C_OP_R:           state_d = S_EXECR;
          C_OP_I:           state_d = S_EXECI;
          C_OP_JAL:         state_d = S_JAL;
          C_OP_BEQ:         state_d = S_BEQ;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == C_OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Reset shows FETCH selects regardless of the abandoned state; enables are masked below.
  assign w_state = rst ? S_FETCH : state_q;

  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_alu_op    = 2'b00;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_illegal   = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    case (w_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_pc_update = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          C_OP_LW, C_OP_SW, C_OP_R, C_OP_I, C_OP_JAL, C_OP_BEQ: w_illegal = 1'b0;
          default: w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = 2'b10;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b01;
        w_branch = 1'b1;
      end
      default: begin
        w_pc_update = 1'b0;
      end
    endcase
  end

  assign PCWrite   = ~rst & (w_pc_update | (w_branch & Zero));
  assign IRWrite   = ~rst & w_irwrite;
  assign MemWrite  = ~rst & w_memwrite;
  assign RegWrite  = ~rst & w_regwrite;
  assign IllegalOp = ~rst & w_illegal;

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      C_OP_SW:  ImmSrc = 2'b01;
      C_OP_BEQ: ImmSrc = 2'b10;
      C_OP_JAL: ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  // Only R-type (op[5]=1) with funct7b5 subtracts; addi with a negative imm stays add.
  always_comb begin
    ALUControl = 3'b000;
    case (w_alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_risc_mc_controller.sv
// +--------------------------------------------------------------------------+
// | tb_alu_risc_mc_controller                                                |
// | Directed self-checking bench for the multicycle control unit.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_risc_mc_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [16:0] w_obs;

  int n_cmp;
  int n_err;

  alu_risc_mc_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl),
    .IllegalOp  (IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign w_obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, RegWrite, ALUControl, IllegalOp};

  // Field order: pcw adr mw irw rs sa sb imm rw ac ill
  function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] imm, input logic rw,
                                     input logic [2:0] ac, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, ac, ill};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [16:0] exp_v;
    rst = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    exp_v = ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b000,0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (w_obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_hold[%0d] got=%b want=%b", i, w_obs, exp_v);
      end
    end
    rst = 1'b0;
    #1;
    exp_v = ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0);
    n_cmp++;
    if (w_obs !== exp_v) begin
      n_err++;
      $display("FAIL reset_release_fetch got=%b want=%b", w_obs, exp_v);
    end
  endtask

  // Entered with the DUT in FETCH; leaves it in FETCH of the next instruction.
  task automatic test_lw();
    logic [16:0] exp_v [6];
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    #1;
    exp_v[0] = ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0);
    exp_v[1] = ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0);
    exp_v[2] = ev(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0);
    exp_v[3] = ev(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0);
    exp_v[4] = ev(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,3'b000,0);
    exp_v[5] = exp_v[0];
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      n_cmp++;
      if (w_obs !== exp_v[i]) begin
        n_err++;
        $display("FAIL lw_cycle%0d got=%b want=%b", i + 1, w_obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_alu_decode();
    logic [6:0]  t_op [7];
    logic [2:0]  t_f3 [7];
    logic        t_f7 [7];
    logic [2:0]  t_ac [7];
    logic [16:0] exp_v [5];
    t_op[0] = 7'b0110011; t_f3[0] = 3'b000; t_f7[0] = 1'b1; t_ac[0] = 3'b001; // sub
    t_op[1] = 7'b0010011; t_f3[1] = 3'b000; t_f7[1] = 1'b1; t_ac[1] = 3'b000; // addi
    t_op[2] = 7'b0110011; t_f3[2] = 3'b010; t_f7[2] = 1'b0; t_ac[2] = 3'b101; // slt
    t_op[3] = 7'b0010011; t_f3[3] = 3'b110; t_f7[3] = 1'b0; t_ac[3] = 3'b011; // ori
    t_op[4] = 7'b0110011; t_f3[4] = 3'b111; t_f7[4] = 1'b0; t_ac[4] = 3'b010; // and
    t_op[5] = 7'b0110011; t_f3[5] = 3'b000; t_f7[5] = 1'b0; t_ac[5] = 3'b000; // add
    t_op[6] = 7'b0110011; t_f3[6] = 3'b001; t_f7[6] = 1'b1; t_ac[6] = 3'b000; // unsupported funct3
    for (int k = 0; k < 7; k++) begin
      op = t_op[k]; funct3 = t_f3[k]; funct7b5 = t_f7[k];
      #1;
      exp_v[0] = ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0);
      exp_v[1] = ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0);
      exp_v[2] = ev(0,0,0,0,2'b00,2'b10,t_op[k][5] ? 2'b00 : 2'b01,2'b00,0,t_ac[k],0);
      exp_v[3] = ev(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000,0);
      exp_v[4] = exp_v[0];
      for (int i = 0; i < 5; i++) begin
        if (i > 0) step();
        n_cmp++;
        if (w_obs !== exp_v[i]) begin
          n_err++;
          $display("FAIL alu_vec%0d_cycle%0d got=%b want=%b", k, i + 1, w_obs, exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_beq();
    logic [16:0] exp_v [4];
    for (int z = 1; z >= 0; z--) begin
      op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = z[0];
      #1;
      exp_v[0] = ev(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,3'b000,0);
      exp_v[1] = ev(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,3'b000,0);
      exp_v[2] = ev(z[0],0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,0);
      exp_v[3] = exp_v[0];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) step();
        n_cmp++;
        if (w_obs !== exp_v[i]) begin
          n_err++;
          $display("FAIL beq_zero%0d_cycle%0d got=%b want=%b", z, i + 1, w_obs, exp_v[i]);
        end
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_v [9];
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    #1;
    exp_v[0] = ev(1,0,0,1,2'b10,2'b00,2'b10,2'b01,0,3'b000,0);
    exp_v[1] = ev(0,0,0,0,2'b00,2'b01,2'b01,2'b01,0,3'b000,0);
    exp_v[2] = ev(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,3'b000,0);
    exp_v[3] = ev(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,0);
    exp_v[4] = ev(1,0,0,1,2'b10,2'b00,2'b10,2'b11,0,3'b000,0);
    exp_v[5] = ev(0,0,0,0,2'b00,2'b01,2'b01,2'b11,0,3'b000,0);
    exp_v[6] = ev(1,0,0,0,2'b00,2'b01,2'b10,2'b11,0,3'b000,0);
    exp_v[7] = ev(0,0,0,0,2'b00,2'b00,2'b00,2'b11,1,3'b000,0);
    exp_v[8] = exp_v[4];
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
        if (i == 4) op = 7'b1101111;
        #1;
      end
      n_cmp++;
      if (w_obs !== exp_v[i]) begin
        n_err++;
        $display("FAIL sw_jal_cycle%0d got=%b want=%b", i + 1, w_obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [16:0] exp_v [3];
    op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0;
    #1;
    exp_v[0] = ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0);
    exp_v[1] = ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,1);
    exp_v[2] = exp_v[0];
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      n_cmp++;
      if (w_obs !== exp_v[i]) begin
        n_err++;
        $display("FAIL illegal_cycle%0d got=%b want=%b", i + 1, w_obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid_lw();
    logic [16:0] exp_v [4];
    logic [16:0] exp_rst;
    logic [16:0] exp_after;
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    #1;
    exp_v[0] = ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0);
    exp_v[1] = ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0);
    exp_v[2] = ev(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0);
    exp_v[3] = ev(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      n_cmp++;
      if (w_obs !== exp_v[i]) begin
        n_err++;
        $display("FAIL rstmid_cycle%0d got=%b want=%b", i + 1, w_obs, exp_v[i]);
      end
    end
    rst = 1'b1;
    #1;
    exp_rst = ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b000,0);
    n_cmp++;
    if (w_obs !== exp_rst) begin
      n_err++;
      $display("FAIL rstmid_in_memread got=%b want=%b", w_obs, exp_rst);
    end
    step();
    rst = 1'b0;
    #1;
    exp_after = exp_v[0];
    n_cmp++;
    if (w_obs !== exp_after) begin
      n_err++;
      $display("FAIL rstmid_refetch got=%b want=%b", w_obs, exp_after);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0;
    test_reset();
    test_lw();
    test_alu_decode();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_mid_lw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
